// File: rtl/ternary_serial_adder_pkg.sv
// Shared balanced-ternary definitions: trit/mode encodings, FSM state codes and trit helper functions.
package ternary_serial_adder_pkg;

  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_BAD  = 2'b10;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [1:0] trit_neg(input logic [1:0] t);
    case (t)
      TRIT_POS: trit_neg = TRIT_NEG;
      TRIT_NEG: trit_neg = TRIT_POS;
      default:  trit_neg = TRIT_ZERO;
    endcase
  endfunction

  function automatic logic trit_is_bad(input logic [1:0] t);
    trit_is_bad = (t == TRIT_BAD);
  endfunction

  // The illegal code reads as zero.
  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    case (t)
      TRIT_POS: trit_val = 3'sd1;
      TRIT_NEG: trit_val = -3'sd1;
      default:  trit_val = 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] trit_enc(input logic signed [2:0] v);
    if (v == 3'sd1)       trit_enc = TRIT_POS;
    else if (v == -3'sd1) trit_enc = TRIT_NEG;
    else                  trit_enc = TRIT_ZERO;
  endfunction

endpackage

// File: rtl/ternary_serial_adder_if.sv
// Operand request / result handshake bundle for the ternary serial adder.
interface ternary_serial_adder_if #(
  parameter int WIDTH = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   op_a;
  logic [2*WIDTH-1:0]   op_b;
  logic [1:0]           cin;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   sum;
  logic [1:0]           cout;
  logic                 enc_err;

  modport master (
    output in_valid, op_a, op_b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, enc_err
  );

  modport slave (
    input  in_valid, op_a, op_b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, enc_err
  );
endinterface

// File: rtl/ternary_serial_adder_trit.sv
// Combinational one-trit balanced-ternary full adder on the two-bit digital trit encoding.
module ternary_trit_adder_d
  import ternary_serial_adder_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic [1:0] cin_i,
  output logic [1:0] sum_o,
  output logic [1:0] cout_o
);
  logic signed [2:0] s;

  always_comb begin
    s = trit_val(a_i) + trit_val(b_i) + trit_val(cin_i);
    if (s >= 3'sd2) begin
      sum_o  = trit_enc(s - 3'sd3);
      cout_o = TRIT_POS;
    end else if (s <= -3'sd2) begin
      sum_o  = trit_enc(s + 3'sd3);
      cout_o = TRIT_NEG;
    end else begin
      sum_o  = trit_enc(s);
      cout_o = TRIT_ZERO;
    end
  end
endmodule

// File: rtl/ternary_serial_adder.sv
// Balanced-ternary add/sub/accumulate unit: WIDTH trits, TPC trits per clock, LS trit first,
// with a carry register between beats and a valid/ready handshake on each side.
module ternary_serial_adder
  import ternary_serial_adder_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int TPC   = 1
) (
  input  logic clk,
  input  logic rst_n,
  ternary_serial_adder_if.slave bus
);
  localparam int BEATS = WIDTH / TPC;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int W2    = 2 * WIDTH;

  if (WIDTH % TPC != 0) begin : g_bad_tpc
    $error("ternary_serial_adder: WIDTH must be a multiple of TPC");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [W2-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, acc_q, acc_d;
  logic [1:0]       carry_q, carry_d, cout_q, cout_d;
  logic             err_q, err_d;

  logic [2*TPC-1:0]        add_s;
  logic [2*TPC+1:0]        chain_c;
  logic [W2+2*TPC-1:0]     sum_cat;
  logic [W2-1:0]           sum_shift;

  function automatic logic [W2-1:0] clean_word(input logic [W2-1:0] w, input logic neg);
    logic [1:0] t;
    clean_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t = trit_is_bad(w[2*i +: 2]) ? TRIT_ZERO : w[2*i +: 2];
      clean_word[2*i +: 2] = neg ? trit_neg(t) : t;
    end
  endfunction

  function automatic logic word_bad(input logic [W2-1:0] w);
    word_bad = 1'b0;
    for (int i = 0; i < WIDTH; i++) word_bad = word_bad | trit_is_bad(w[2*i +: 2]);
  endfunction

  // Carry ripples through TPC trit adders per beat.
  assign chain_c[1:0] = carry_q;
  for (genvar g = 0; g < TPC; g++) begin : g_trit
    ternary_trit_adder_d u_trit (
      .a_i   (a_q[2*g +: 2]),
      .b_i   (b_q[2*g +: 2]),
      .cin_i (chain_c[2*g +: 2]),
      .sum_o (add_s[2*g +: 2]),
      .cout_o(chain_c[2*g+2 +: 2])
    );
  end

  assign sum_cat   = {add_s, sum_q};
  assign sum_shift = sum_cat[W2+2*TPC-1:2*TPC];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          mode_d  = bus.mode;
          carry_d = trit_is_bad(bus.cin) ? TRIT_ZERO : bus.cin;
          case (bus.mode)
            MODE_ADD: begin
              a_d   = clean_word(bus.op_a, 1'b0);
              b_d   = clean_word(bus.op_b, 1'b0);
              err_d = word_bad(bus.op_a) | word_bad(bus.op_b) | trit_is_bad(bus.cin);
            end
            MODE_SUB: begin
              a_d   = clean_word(bus.op_a, 1'b0);
              b_d   = clean_word(bus.op_b, 1'b1);
              err_d = word_bad(bus.op_a) | word_bad(bus.op_b) | trit_is_bad(bus.cin);
            end
            MODE_ACC: begin
              a_d   = acc_q;
              b_d   = clean_word(bus.op_b, 1'b0);
              err_d = word_bad(bus.op_b) | trit_is_bad(bus.cin);
            end
            default: begin
              a_d     = clean_word(bus.op_a, 1'b0);
              b_d     = '0;
              carry_d = TRIT_ZERO;
              err_d   = word_bad(bus.op_a) | trit_is_bad(bus.cin);
            end
          endcase
        end
      end
      ST_RUN: begin
        a_d     = a_q >> (2 * TPC);
        b_d     = b_q >> (2 * TPC);
        sum_d   = sum_shift;
        carry_d = chain_c[2*TPC +: 2];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          state_d = ST_DONE;
          cout_d  = chain_c[2*TPC +: 2];
          // Carry-out is dropped here, so the accumulator wraps modulo 3^WIDTH.
          if (mode_q == MODE_ACC || mode_q == MODE_LOAD) acc_d = sum_shift;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      carry_q <= TRIT_ZERO;
      cout_q  <= TRIT_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.enc_err   = err_q;
endmodule

// File: tb/tb_ternary_serial_adder.sv
// Directed checks of the ternary serial adder: a WIDTH=3/TPC=1 instance and a WIDTH=9/TPC=3 instance.
module tb_ternary_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   lat;

  always #5 clk = ~clk;

  ternary_serial_adder_if #(.WIDTH(3)) b1 ();
  ternary_serial_adder_if #(.WIDTH(9)) b2 ();

  ternary_serial_adder #(.WIDTH(3), .TPC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ternary_serial_adder #(.WIDTH(9), .TPC(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, present one request, return cycles from accepting edge to out_valid.
  task automatic start1(input logic [1:0] m, input logic [5:0] a, input logic [5:0] b,
                        input logic [1:0] c, output int n);
    int w;
    w = 0;
    while (!b1.in_ready && w < 50) begin tick(); w++; end
    b1.mode = m; b1.op_a = a; b1.op_b = b; b1.cin = c;
    b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    n = 0;
    while (!b1.out_valid && n < 50) begin tick(); n++; end
  endtask

  task automatic res1(input string tag, input logic [5:0] s, input logic [1:0] co, input logic e);
    chk({tag, "_sum"}, 64'(b1.sum), 64'(s));
    chk({tag, "_cout"}, 64'(b1.cout), 64'(co));
    chk({tag, "_err"}, 64'(b1.enc_err), 64'(e));
  endtask

  task automatic hs1(input string tag);
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, 64'(b1.out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(b1.in_ready), 64'd1);
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.out_ready = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.cin = '0; b1.mode = '0;
    b2.in_valid = 1'b0; b2.out_ready = 1'b0; b2.op_a = '0; b2.op_b = '0; b2.cin = '0; b2.mode = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(b1.in_ready), 64'd0);
    chk("rst_out_valid", 64'(b1.out_valid), 64'd0);
    res1("rst", 6'h00, 2'b00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 64'(b1.in_ready), 64'd1);

    // ADD 13+1 with 10 cycles of backpressure; a SUB request is held during DONE
    start1(2'b00, 6'h15, 6'h01, 2'b00, lat);
    chk("add_latency", 64'(lat), 64'd3);
    res1("add", 6'h3F, 2'b01, 1'b0);
    b1.mode = 2'b01; b1.op_a = 6'h1F; b1.op_b = 6'h1D; b1.cin = 2'b00;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 64'(b1.out_valid), 64'd1);
      chk("bp_in_ready", 64'(b1.in_ready), 64'd0);
      chk("bp_sum", 64'(b1.sum), 64'h3F);
    end
    b1.out_ready = 1'b1;
    tick();
    b1.out_ready = 1'b0;
    chk("bp_rel_vld", 64'(b1.out_valid), 64'd0);
    chk("bp_rel_rdy", 64'(b1.in_ready), 64'd1);
    tick();
    b1.in_valid = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 50) begin tick(); lat++; end
    chk("sub_latency", 64'(lat), 64'd3);
    res1("sub", 6'h0D, 2'b00, 1'b0);
    hs1("sub");

    // LOAD 4, ACC +4, ACC +4
    start1(2'b11, 6'h05, 6'h3F, 2'b01, lat);
    res1("load", 6'h05, 2'b00, 1'b0);
    hs1("load");
    start1(2'b10, 6'h3F, 6'h05, 2'b00, lat);
    res1("acc1", 6'h13, 2'b00, 1'b0);
    hs1("acc1");
    start1(2'b10, 6'h00, 6'h05, 2'b00, lat);
    res1("acc2", 6'h14, 2'b00, 1'b0);
    hs1("acc2");

    // Most negative: -13 + -13 + -1 = -27 -> sum 000, cout -
    start1(2'b00, 6'h3F, 6'h3F, 2'b11, lat);
    res1("neg_ovf", 6'h00, 2'b11, 1'b0);
    hs1("neg_ovf");

    // Illegal code in A trit 0, then a legal request clears enc_err
    start1(2'b00, 6'h02, 6'h01, 2'b00, lat);
    res1("illegal", 6'h01, 2'b00, 1'b1);
    hs1("illegal");
    start1(2'b00, 6'h04, 6'h00, 2'b00, lat);
    res1("legal_after", 6'h04, 2'b00, 1'b0);
    hs1("legal_after");

    // Reset one beat into RUN: no result, state and accumulator cleared
    b1.mode = 2'b00; b1.op_a = 6'h15; b1.op_b = 6'h01; b1.cin = 2'b00;
    b1.in_valid = 1'b1;
    tick();
    b1.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_in_ready", 64'(b1.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(b1.out_valid), 64'd0);
    res1("mid_rst", 6'h00, 2'b00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_valid", 64'(b1.out_valid), 64'd0);
    end
    start1(2'b10, 6'h00, 6'h01, 2'b00, lat);
    res1("acc_after_rst", 6'h01, 2'b00, 1'b0);
    hs1("acc_after_rst");

    // WIDTH=9, TPC=3 instance: ADD 13+1
    b2.mode = 2'b00; b2.op_a = 18'h00015; b2.op_b = 18'h00001; b2.cin = 2'b00;
    chk("w9_in_ready", 64'(b2.in_ready), 64'd1);
    b2.in_valid = 1'b1;
    tick();
    b2.in_valid = 1'b0;
    lat = 0;
    while (!b2.out_valid && lat < 50) begin tick(); lat++; end
    chk("w9_latency", 64'(lat), 64'd3);
    chk("w9_sum", 64'(b2.sum), 64'h0007F);
    chk("w9_cout", 64'(b2.cout), 64'd0);
    chk("w9_err", 64'(b2.enc_err), 64'd0);
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
    chk("w9_vld_drop", 64'(b2.out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
